// File: rtl/cpu_datapath.sv
// Register-file and ALU datapath for the 16-bit CPU: R0-R7, A, G, PC and one
// shared bus; every enable acts in parallel on the pre-edge bus at each clock.
module cpu_datapath #(
    parameter int                 DATA_W   = 16,
    parameter logic [DATA_W-1:0]  PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rin,
    input  logic [7:0]        rout,
    input  logic              gin,
    input  logic              gout,
    input  logic              pcin,
    input  logic              pcout,
    input  logic              pc_inc,
    input  logic              addsub,
    input  logic              xorctrl,
    input  logic              a_in,
    input  logic              ctrl_out,
    input  logic [DATA_W-1:0] bus_out,
    output logic [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] pc,
    output logic              zf,
    output logic              cf,
    output logic              bus_err,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NSRC = 11;

    logic [DATA_W-1:0] r_q [8];
    logic [DATA_W-1:0] r_d [8];
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] g_q, g_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              zf_q, zf_d;
    logic              cf_q, cf_d;
    logic              bus_err_q, bus_err_d;

    logic [NSRC-1:0]   src_sel;
    logic              multi_src;
    logic [DATA_W-1:0] bus_val;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cf;

    // Clearing the lowest set bit leaves something only if two or more sources drive.
    assign src_sel   = {ctrl_out, pcout, gout, rout};
    assign multi_src = |(src_sel & (src_sel - NSRC'(1)));

    always_comb begin
        bus_val = '0;
        if (!multi_src) begin
            for (int i = 0; i < 8; i++) begin
                if (rout[i]) bus_val = bus_val | r_q[i];
            end
            if (gout)     bus_val = bus_val | g_q;
            if (pcout)    bus_val = bus_val | pc_q;
            if (ctrl_out) bus_val = bus_val | bus_out;
        end
    end

    // The top bit of the extended difference is the unsigned borrow (A < bus).
    assign sum_ext  = {1'b0, a_q} + {1'b0, bus_val};
    assign diff_ext = {1'b0, a_q} - {1'b0, bus_val};

    always_comb begin
        alu_res = sum_ext[DATA_W-1:0];
        alu_cf  = sum_ext[DATA_W];
        if (xorctrl) begin
            alu_res = a_q ^ bus_val;
            alu_cf  = 1'b0;
        end else if (addsub) begin
            alu_res = diff_ext[DATA_W-1:0];
            alu_cf  = diff_ext[DATA_W];
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            r_d[i] = rin[i] ? bus_val : r_q[i];
        end
        a_d       = a_in ? bus_val : a_q;
        g_d       = g_q;
        zf_d      = zf_q;
        cf_d      = cf_q;
        if (gin) begin
            g_d  = alu_res;
            zf_d = (alu_res == '0);
            cf_d = alu_cf;
        end
        pc_d      = pc_q;
        if (pcin) begin
            pc_d = bus_val;
        end else if (pc_inc) begin
            pc_d = pc_q + DATA_W'(1);
        end
        bus_err_d = bus_err_q | multi_src;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_q[i] <= '0;
            end
            a_q       <= '0;
            g_q       <= '0;
            pc_q      <= PC_RESET;
            zf_q      <= 1'b0;
            cf_q      <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                r_q[i] <= r_d[i];
            end
            a_q       <= a_d;
            g_q       <= g_d;
            pc_q      <= pc_d;
            zf_q      <= zf_d;
            cf_q      <= cf_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus      = bus_val;
    assign pc       = pc_q;
    assign zf       = zf_q;
    assign cf       = cf_q;
    assign bus_err  = bus_err_q;
    assign dbg_data = r_q[dbg_sel];

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Register-file and ALU datapath for the 16-bit CPU, directly downstream of `control_unit`. It consumes the control unit's one-hot register strobes, bus-source selects and ALU controls. It owns the eight general registers R0–R7, the A and G ALU registers, the program counter and a single shared 16-bit bus. Every register transfer the control unit sequences for load, move, add/sub/xor, ldpc and branch happens here, one bus transfer per clock.

## Interface
Parameters:
- DATA_W, 16, width of the bus and of every register (the ALU is DATA_W wide).
- PC_RESET, 16'h0000, reset value of PC.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- rin  in  8  one-hot; bit i loads R[i] from the bus.
- rout  in  8  one-hot; bit i drives R[i] onto the bus.
- gin  in  1  G loads the ALU result; flags update.
- gout  in  1  G drives the bus.
- pcin  in  1  PC loads from the bus.
- pcout  in  1  PC drives the bus.
- pc_inc  in  1  PC increments by 1 (asserted by fetch).
- addsub  in  1  0 = A+bus, 1 = A−bus.
- xorctrl  in  1  1 = A^bus; overrides addsub.
- a_in  in  1  A loads from the bus.
- ctrl_out  in  1  control-unit immediate drives the bus.
- bus_out  in  DATA_W  immediate value from the control unit.
- bus  out  DATA_W  current bus value (combinational).
- pc  out  DATA_W  PC register.
- zf  out  1  zero flag: last G result == 0.
- cf  out  1  carry out (add) or borrow (sub); 0 on xor.
- bus_err  out  1  sticky: a bus-source conflict occurred.
- dbg_sel  in  3  debug register select.
- dbg_data  out  DATA_W  R[dbg_sel], combinational.

## Operation
- Bus sources are rout[7:0], gout, pcout and ctrl_out.
  - With exactly one source active, bus equals that source.
  - With no source active, bus = 0.
  - With two or more sources active, bus = 0, and bus_err sets at the next edge and stays set until rst.
- ALU (combinational on A and bus):
  - xorctrl=1: A^bus.
  - Else addsub=0: A+bus. Else: A−bus.
  - Results are modulo 2^DATA_W.
  - cf is bit DATA_W of the (DATA_W+1)-bit add, or the borrow (A<bus unsigned) on subtract.
- At each rising edge, when rst=0, all enables act in parallel on the pre-edge bus and register values:
  - R[i] <= bus for every rin[i]=1.
  - A <= bus if a_in.
  - G <= ALU result if gin, and zf/cf update together with G.
  - PC: if pcin, PC <= bus; else if pc_inc, PC <= PC+1 (wraps 0xFFFF -> 0x0000); else PC holds.
- Instruction mappings:
  - Move: rout[y]+rin[x] in 1 cycle.
  - Load: ctrl_out+rin[x].
  - Add/sub/xor: A<=Rx, then G<=A op Ry, then Rx<=G (3 cycles).
  - ldpc: pcout+rin[x].
  - Branch: rout[x]+pcin.

## Timing
- On rst=1 at an edge: R0–R7=0, A=0, G=0, PC=PC_RESET, zf=0, cf=0, bus_err=0. rst dominates all enables in the same cycle.
- Reset mid-sequence (for example between A-load and gin) discards partial state; no pending operation survives.
- Latency:
  - bus, dbg_data: 0 cycles (combinational).
  - Register writes: visible the cycle after the enable.
  - pc, zf, cf, bus_err: registered outputs.
- Simultaneous events:
  - rout[i] & rin[i]: R[i] reloads itself (unchanged).
  - a_in & gin: G uses the old A.
  - pcout & pcin: PC unchanged; pc_inc is ignored.
  - pcin & pc_inc: pcin wins.
  - Multiple rin bits set: all selected registers load the bus.
- The conflict check uses only bus-source signals. Multiple rin bits are legal.

## Test plan
- Reset, then load: rst=1 for 1 cycle (all outputs 0, pc=PC_RESET). Then ctrl_out=1, bus_out=16'h00FF, rin=8'b00000100 -> next cycle dbg_sel=2 gives 16'h00FF.
- Move: with R2=16'h00FF, drive rout[2] and rin[7] -> R7=16'h00FF next cycle, bus=16'h00FF during the transfer cycle.
- Add/sub/xor with flags:
  - R1=16'hFFFF, R2=16'h0001. A<=R1, then G<=A+R2 -> G=0, zf=1, cf=1.
  - The same registers with addsub=1 -> G=16'hFFFE, cf=0, zf=0.
  - With xorctrl=1 -> G=16'hFFFE, cf=0.
- ldpc/branch/increment:
  - pc_inc for 3 cycles from 0 -> pc=3.
  - pcout+rin[0] -> R0=3.
  - R4=16'h1234, rout[4]+pcin -> pc=16'h1234.
  - pc=16'hFFFF, pc_inc -> 0.
- Bus conflict: gout and rout[3] together -> bus=0, bus_err=1 next cycle and held through later clean transfers. rst clears it.
- Reset mid-add: after A<=R1, assert rst on the gin cycle -> G=0, zf=0, and registers are all 0 the next cycle.
